// File: rtl/ram_arb_pkg.sv
// Shared definitions for the ram_4x8 arbiter: state encoding, requester ids and geometry.
// The optional per-requester counters are enabled with ARB_ACCESS_COUNT_EN.
package ram_arb_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] value);
        if (value == {DATA_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(DATA_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin winner selection with a registered fairness pointer.
// The pointer moves to the losing requester whenever a grant is issued.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic b_req,
    input  logic grant_en,
    output logic any_req,
    output logic winner
);

    logic ptr_r;
    logic winner_s;

    // Pick the lone requester, or the pointer's choice when both contend.
    always_comb begin
        winner_s = REQ_A;
        if (a_req && b_req) begin
            winner_s = ptr_r;
        end else if (b_req) begin
            winner_s = REQ_B;
        end else begin
            winner_s = REQ_A;
        end
    end

    assign any_req = a_req | b_req;
    assign winner  = winner_s;

    // Pointer flips to the loser only on the cycle a grant is actually made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= REQ_A;
        end else if (grant_en && (a_req || b_req)) begin
            ptr_r <= ~winner_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/ram_4x8_arbiter.sv
// Arbiter and access sequencer for the shared ram_4x8: IDLE -> ACCESS -> RESP per transaction.
// Define ARB_ACCESS_COUNT_EN to add saturating completed-transaction counters a_count/b_count.
module ram_4x8_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_enable,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
`ifdef ARB_ACCESS_COUNT_EN
    ,
    output logic [DATA_W-1:0] a_count,
    output logic [DATA_W-1:0] b_count
`endif
);

    arb_state_t        state_r;
    logic              win_r;
    logic              we_r;
    logic              any_req_s;
    logic              winner_s;
    logic              grant_en_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    assign grant_en_s = (state_r == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .b_req    (b_req),
        .grant_en (grant_en_s),
        .any_req  (any_req_s),
        .winner   (winner_s)
    );

    // Route the winning requester's fields toward the grant latches.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (winner_s == REQ_B) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
    end

    // Sequencer FSM; ram_addr/ram_din double as the latched address and write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            win_r      <= REQ_A;
            we_r       <= 1'b0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            rdata      <= {DATA_W{1'b0}};
            ram_enable <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= {ADDR_W{1'b0}};
            ram_din    <= {DATA_W{1'b0}};
            busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r    <= ACCESS;
                        win_r      <= winner_s;
                        we_r       <= sel_we_s;
                        ram_enable <= 1'b1;
                        ram_we     <= sel_we_s;
                        ram_addr   <= sel_addr_s;
                        ram_din    <= sel_wdata_s;
                        a_gnt      <= (winner_s == REQ_A);
                        b_gnt      <= (winner_s == REQ_B);
                        busy       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r    <= RESP;
                    ram_enable <= 1'b0;
                    ram_we     <= 1'b0;
                    a_gnt      <= 1'b0;
                    b_gnt      <= 1'b0;
                    a_done     <= (win_r == REQ_A);
                    b_done     <= (win_r == REQ_B);
                    if (!we_r) begin
                        rdata <= ram_dout;
                    end else begin
                        rdata <= rdata;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    a_done  <= 1'b0;
                    b_done  <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    ram_enable <= 1'b0;
                    ram_we     <= 1'b0;
                    a_gnt      <= 1'b0;
                    b_gnt      <= 1'b0;
                    a_done     <= 1'b0;
                    b_done     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_ACCESS_COUNT_EN
    // Count completions; the new value appears together with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= {DATA_W{1'b0}};
            b_count <= {DATA_W{1'b0}};
        end else if (state_r == ACCESS) begin
            if (win_r == REQ_A) begin
                a_count <= sat_inc(a_count);
            end else begin
                b_count <= sat_inc(b_count);
            end
        end else begin
            a_count <= a_count;
            b_count <= b_count;
        end
    end
`endif

endmodule
